// File: rtl/lock_session_if.sv
// lock_session_if: button, checker and indication signals of lock_session_ctrl.
interface lock_session_if;
   logic       edit_sw;
   logic       load_pulse;
   logic       ok_pulse;
   logic       admin_pulse;
   logic [3:0] digit_in;
   logic       check_done;
   logic       check_pass;
   logic       digit_load_en;
   logic       clear_entry;
   logic       check_req;
   logic [2:0] digit_count;
   logic [1:0] err_count;
   logic [2:0] state;
   logic [4:0] sec_left;
   modport master (
      output edit_sw, load_pulse, ok_pulse, admin_pulse, digit_in, check_done, check_pass,
      input  digit_load_en, clear_entry, check_req, digit_count, err_count, state, sec_left
   );
   modport slave (
      input  edit_sw, load_pulse, ok_pulse, admin_pulse, digit_in, check_done, check_pass,
      output digit_load_en, clear_entry, check_req, digit_count, err_count, state, sec_left
   );
endinterface

// File: rtl/lock_session_ctrl.sv
// lock_session_ctrl: digit-lock session sequencer (WAIT/EDIT/CHECK/UNLOCK/ALARM) with per-second timeouts.
// Define ADMIN_UNLOCK_EN to let admin_pulse force UNLOCK from WAIT/EDIT, and force a pass in CHECK.
module lock_session_ctrl #(
   parameter int TICK_DIV         = 100000000,
   parameter int EDIT_TIMEOUT_S   = 10,
   parameter int UNLOCK_TIMEOUT_S = 20,
   parameter int MAX_ERRORS       = 3,
   parameter int DIGITS           = 4
) (
   input logic           clk,
   input logic           rst,
   lock_session_if.slave bus
);
`ifdef ADMIN_UNLOCK_EN
   localparam bit ADMIN = 1'b1;
`else
   localparam bit ADMIN = 1'b0;
`endif
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [4:0] ET = 5'(EDIT_TIMEOUT_S);
   localparam logic [4:0] UT = 5'(UNLOCK_TIMEOUT_S);
   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_EDIT   = 3'd1,
      S_UNLOCK = 3'd2,
      S_ALARM  = 3'd3,
      S_CHECK  = 3'd4
   } state_t;
   state_t        st;
   logic          edit_q;
   logic [PW-1:0] presc;
   logic [2:0]    dcnt;
   logic [1:0]    ecnt;
   logic [4:0]    sec;
   logic          load_en;
   logic          clr;
   logic          req;
   logic          admin_pend;
   logic          tick;
   logic          load_ok;
   logic          last_err;
   assign tick     = presc == PW'(TICK_DIV - 1);
   assign load_ok  = bus.load_pulse && bus.digit_in <= 4'd9 && dcnt < 3'(DIGITS);
   assign last_err = {1'b0, ecnt} + 3'd1 == 3'(MAX_ERRORS);
   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= S_WAIT;
         edit_q     <= bus.edit_sw;
         presc      <= '0;
         dcnt       <= '0;
         ecnt       <= '0;
         sec        <= '0;
         load_en    <= 1'b0;
         clr        <= 1'b0;
         req        <= 1'b0;
         admin_pend <= 1'b0;
      end else begin
         edit_q  <= bus.edit_sw;
         load_en <= 1'b0;
         clr     <= 1'b0;
         presc   <= tick ? '0 : presc + PW'(1);
         case (st)
            S_WAIT:
               if (ADMIN && bus.admin_pulse) begin
                  st    <= S_UNLOCK;
                  sec   <= UT;
                  ecnt  <= '0;
                  presc <= '0;
               end else if (bus.edit_sw && !edit_q) begin
                  st    <= S_EDIT;
                  clr   <= 1'b1;
                  dcnt  <= '0;
                  sec   <= ET;
                  presc <= '0;
               end
            S_EDIT:
               if (!bus.edit_sw) begin
                  st    <= S_WAIT;
                  clr   <= 1'b1;
                  dcnt  <= '0;
                  sec   <= '0;
                  presc <= '0;
               end else if (ADMIN && bus.admin_pulse) begin
                  st    <= S_UNLOCK;
                  sec   <= UT;
                  ecnt  <= '0;
                  presc <= '0;
               end else if (load_ok) begin
                  // an accepted digit beats a coincident tick and restarts the second
                  load_en <= 1'b1;
                  dcnt    <= dcnt + 3'd1;
                  sec     <= ET;
                  presc   <= '0;
               end else if (bus.ok_pulse && dcnt == 3'(DIGITS)) begin
                  st    <= S_CHECK;
                  req   <= 1'b1;
                  sec   <= '0;
                  presc <= '0;
               end else if (tick) begin
                  sec <= sec - 5'd1;
                  if (sec == 5'd1) begin
                     st   <= S_WAIT;
                     clr  <= 1'b1;
                     dcnt <= '0;
                  end
               end
            S_CHECK: begin
               if (ADMIN && bus.admin_pulse)
                  admin_pend <= 1'b1;
               if (bus.check_done) begin
                  req        <= 1'b0;
                  admin_pend <= 1'b0;
                  presc      <= '0;
                  if (bus.check_pass || (ADMIN && (admin_pend || bus.admin_pulse))) begin
                     st   <= S_UNLOCK;
                     ecnt <= '0;
                     sec  <= UT;
                  end else if (last_err) begin
                     st   <= S_ALARM;
                     ecnt <= 2'(MAX_ERRORS);
                  end else begin
                     st   <= S_EDIT;
                     ecnt <= ecnt + 2'd1;
                     clr  <= 1'b1;
                     dcnt <= '0;
                     sec  <= ET;
                  end
               end
            end
            S_UNLOCK:
               if (bus.ok_pulse || (tick && sec == 5'd1)) begin
                  st    <= S_WAIT;
                  clr   <= 1'b1;
                  dcnt  <= '0;
                  sec   <= '0;
                  presc <= '0;
               end else if (tick)
                  sec <= sec - 5'd1;
            S_ALARM:
               if (bus.admin_pulse) begin
                  st    <= S_WAIT;
                  ecnt  <= '0;
                  clr   <= 1'b1;
                  dcnt  <= '0;
                  presc <= '0;
               end
            default: st <= S_WAIT;
         endcase
      end
   end
   assign bus.state         = st;
   assign bus.digit_load_en = load_en;
   assign bus.clear_entry   = clr;
   assign bus.check_req     = req;
   assign bus.digit_count   = dcnt;
   assign bus.err_count     = ecnt;
   assign bus.sec_left      = sec;
endmodule

// File: tb/tb_lock_session_ctrl.sv
// tb_lock_session_ctrl: vector table plus scoreboard queue for lock_session_ctrl (TICK_DIV=4, 10/20 s, 3 errors, 4 digits).
module tb_lock_session_ctrl;
   typedef enum int {E_NONE, E_LD, E_OK, E_AD, E_PASS, E_FAIL} ev_t;
   typedef struct {
      logic       es;
      ev_t        ev;
      logic [3:0] dg;
      int         n;
      logic [2:0] st;
      logic [2:0] dc;
      logic [1:0] ec;
      logic [4:0] sl;
      logic       le;
      logic       ce;
      logic       rq;
   } vec_t;
`ifdef ADMIN_UNLOCK_EN
   localparam bit ADM = 1'b1;
`else
   localparam bit ADM = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   vec_t tbl[$];
   vec_t sb[$];
   int tests = 0;
   int fails = 0;
   int idx = 0;
   lock_session_if bus();
   lock_session_ctrl #(
      .TICK_DIV(4), .EDIT_TIMEOUT_S(10), .UNLOCK_TIMEOUT_S(20), .MAX_ERRORS(3), .DIGITS(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );
   always #5 clk = ~clk;
   function automatic vec_t mk(input logic es, input ev_t ev, input int dg, input int n,
                               input int st, input int dc, input int ec, input int sl,
                               input logic le, input logic ce, input logic rq);
      vec_t v;
      v.es = es;
      v.ev = ev;
      v.dg = 4'(dg);
      v.n  = n;
      v.st = 3'(st);
      v.dc = 3'(dc);
      v.ec = 2'(ec);
      v.sl = 5'(sl);
      v.le = le;
      v.ce = ce;
      v.rq = rq;
      return v;
   endfunction
   task automatic add(input logic es, input ev_t ev, input int dg, input int n,
                      input int st, input int dc, input int ec, input int sl,
                      input logic le, input logic ce, input logic rq);
      tbl.push_back(mk(es, ev, dg, n, st, dc, ec, sl, le, ce, rq));
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask
   task automatic check_out();
      vec_t e;
      string t;
      e = sb.pop_front();
      t = $sformatf("v%0d", idx);
      chk({t, ".state"}, 32'(bus.state), 32'(e.st));
      chk({t, ".digit_count"}, 32'(bus.digit_count), 32'(e.dc));
      chk({t, ".err_count"}, 32'(bus.err_count), 32'(e.ec));
      chk({t, ".sec_left"}, 32'(bus.sec_left), 32'(e.sl));
      chk({t, ".digit_load_en"}, 32'(bus.digit_load_en), 32'(e.le));
      chk({t, ".clear_entry"}, 32'(bus.clear_entry), 32'(e.ce));
      chk({t, ".check_req"}, 32'(bus.check_req), 32'(e.rq));
      idx++;
   endtask
   task automatic clear_pulses();
      bus.load_pulse  = 1'b0;
      bus.ok_pulse    = 1'b0;
      bus.admin_pulse = 1'b0;
      bus.check_done  = 1'b0;
      bus.check_pass  = 1'b0;
   endtask
   task automatic step(input vec_t v);
      bus.edit_sw     = v.es;
      bus.load_pulse  = v.ev == E_LD;
      bus.ok_pulse    = v.ev == E_OK;
      bus.admin_pulse = v.ev == E_AD;
      bus.check_done  = v.ev == E_PASS || v.ev == E_FAIL;
      bus.check_pass  = v.ev == E_PASS;
      bus.digit_in    = v.dg;
      sb.push_back(v);
      repeat (v.n) begin
         @(posedge clk);
         #1;
         clear_pulses();
      end
      check_out();
   endtask
   task automatic rst_cycle(input logic es);
      bus.edit_sw = es;
      clear_pulses();
      rst = 1'b1;
      sb.push_back(mk(es, E_NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_out();
   endtask
   task automatic fill_digits(input int ec);
      for (int d = 1; d <= 4; d++)
         add(1, E_LD, d, 1, 1, d, ec, 10, 1, 0, 0);
   endtask
   initial begin
      // opening session, bad digit, overflow, then a passing check and manual re-lock
      add(1, E_NONE, 0, 1, 1, 0, 0, 10, 0, 1, 0);
      add(1, E_LD, 1, 1, 1, 1, 0, 10, 1, 0, 0);
      add(1, E_LD, 2, 1, 1, 2, 0, 10, 1, 0, 0);
      add(1, E_LD, 10, 1, 1, 2, 0, 10, 0, 0, 0);
      add(1, E_LD, 3, 1, 1, 3, 0, 10, 1, 0, 0);
      add(1, E_LD, 4, 1, 1, 4, 0, 10, 1, 0, 0);
      add(1, E_LD, 5, 1, 1, 4, 0, 10, 0, 0, 0);
      add(1, E_OK, 0, 1, 4, 4, 0, 0, 0, 0, 1);
      add(1, E_NONE, 0, 3, 4, 4, 0, 0, 0, 0, 1);
      add(1, E_PASS, 0, 1, 2, 4, 0, 20, 0, 0, 0);
      add(1, E_LD, 1, 1, 2, 4, 0, 20, 0, 0, 0);
      add(1, E_OK, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      add(0, E_NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      // three failing attempts lead to ALARM
      add(1, E_NONE, 0, 1, 1, 0, 0, 10, 0, 1, 0);
      for (int a = 1; a <= 3; a++) begin
         fill_digits(a - 1);
         add(1, E_OK, 0, 1, 4, 4, a - 1, 0, 0, 0, 1);
         if (a < 3) add(1, E_FAIL, 0, 1, 1, 0, a, 10, 0, 1, 0);
         else       add(1, E_FAIL, 0, 1, 3, 4, 3, 0, 0, 0, 0);
      end
      add(1, E_OK, 0, 1, 3, 4, 3, 0, 0, 0, 0);
      add(1, E_LD, 5, 1, 3, 4, 3, 0, 0, 0, 0);
      add(1, E_PASS, 0, 1, 3, 4, 3, 0, 0, 0, 0);
      add(1, E_AD, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      // EDIT countdown, load on the tick at sec_left=1, then full idle timeout
      add(0, E_NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, E_NONE, 0, 1, 1, 0, 0, 10, 0, 1, 0);
      add(1, E_NONE, 0, 4, 1, 0, 0, 9, 0, 0, 0);
      add(1, E_NONE, 0, 3, 1, 0, 0, 9, 0, 0, 0);
      add(1, E_NONE, 0, 1, 1, 0, 0, 8, 0, 0, 0);
      add(1, E_NONE, 0, 28, 1, 0, 0, 1, 0, 0, 0);
      add(1, E_NONE, 0, 3, 1, 0, 0, 1, 0, 0, 0);
      add(1, E_LD, 7, 1, 1, 1, 0, 10, 1, 0, 0);
      add(1, E_NONE, 0, 39, 1, 1, 0, 1, 0, 0, 0);
      add(1, E_NONE, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      // UNLOCK idle timeout
      add(0, E_NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, E_NONE, 0, 1, 1, 0, 0, 10, 0, 1, 0);
      fill_digits(0);
      add(1, E_OK, 0, 1, 4, 4, 0, 0, 0, 0, 1);
      add(1, E_PASS, 0, 1, 2, 4, 0, 20, 0, 0, 0);
      add(1, E_NONE, 0, 79, 2, 4, 0, 1, 0, 0, 0);
      add(1, E_NONE, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      // short ok ignored; edit_sw low beats a coincident ok
      add(0, E_NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, E_NONE, 0, 1, 1, 0, 0, 10, 0, 1, 0);
      add(1, E_LD, 3, 1, 1, 1, 0, 10, 1, 0, 0);
      add(1, E_OK, 0, 1, 1, 1, 0, 10, 0, 0, 0);
      add(0, E_OK, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      add(0, E_AD, 0, 1, ADM ? 2 : 0, 0, 0, ADM ? 20 : 0, 0, 0, 0);
      clear_pulses();
      bus.digit_in = 4'd0;
      bus.edit_sw  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      sb.push_back(mk(1, E_NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      check_out();
      rst = 1'b0;
      step(mk(1, E_NONE, 0, 3, 0, 0, 0, 0, 0, 0, 0));
      step(mk(0, E_NONE, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      foreach (tbl[i]) step(tbl[i]);
      // reset while a check is outstanding
      rst_cycle(1'b0);
      step(mk(1, E_NONE, 0, 1, 1, 0, 0, 10, 0, 1, 0));
      for (int d = 1; d <= 4; d++) step(mk(1, E_LD, d, 1, 1, d, 0, 10, 1, 0, 0));
      step(mk(1, E_OK, 0, 1, 4, 4, 0, 0, 0, 0, 1));
      rst_cycle(1'b1);
      step(mk(1, E_NONE, 0, 2, 0, 0, 0, 0, 0, 0, 0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
